lane_key_input: RTL and testbench

//  Conditions the two raw lane-change buttons into the 2-bit ctl command that drives the lane-position

---
 rtl/lane_pkg.sv | 12 +
 rtl/key_debounce.sv | 40 ++++
 rtl/lane_key_input.sv | 91 +++++++++
 tb/tb_lane_key_input.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/lane_pkg.sv
// Shared command encodings and repeat-FSM state type for the lane-change key conditioner.
package lane_pkg;
  localparam logic [1:0] CTL_NONE  = 2'b00;
  localparam logic [1:0] CTL_LEFT  = 2'b01;
  localparam logic [1:0] CTL_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    RS_IDLE  = 2'b00,
    RS_DELAY = 2'b01,
    RS_RPT   = 2'b10
  } rpt_state_t;
endpackage

// File: rtl/key_debounce.sv
// One button: 2-flop synchroniser, consecutive-cycle debounce counter, stable level and rise strobe.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic stable,
  output logic rise
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync     <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync     <= {sync[0], btn};
      stable_q <= stable;
      // any sample agreeing with the stable level throws away accumulated credit
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = stable & ~stable_q;
endmodule

// File: rtl/lane_key_input.sv
// Turns two raw lane buttons into one-cycle left/right ctl pulses with optional auto-repeat.
module lane_key_input
  import lane_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_RATE     = 25000000,
  parameter int CNT_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_l,
  input  logic       btn_r,
  output logic [1:0] ctl,
  output logic [1:0] key_lvl
);
  localparam int NUM_KEYS = 2;
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

  logic [NUM_KEYS-1:0] btn, stab, rise, press, pulse;
  rpt_state_t          state, state_nxt;
  logic [CNT_W-1:0]    rcnt, rcnt_nxt;
  logic                key, key_nxt;
  logic                held, other;

  assign btn = {btn_r, btn_l};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn[i]),
      .stable(stab[i]),
      .rise  (rise[i])
    );
  end

  assign key_lvl = stab;
  // a press only counts while the opposite key is up; simultaneous rises cancel each other
  assign press = rise & ~{stab[0], stab[1]};
  assign held  = stab[key];
  assign other = stab[~key];

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    key_nxt   = key;
    pulse     = press;
    case (state)
      RS_IDLE: begin
        if (REPEAT_DELAY != 0 && press != '0) begin
          state_nxt = RS_DELAY;
          rcnt_nxt  = '0;
          key_nxt   = press[1];
        end
      end
      default: begin
        if (!held || other) begin
          state_nxt = RS_IDLE;
          rcnt_nxt  = '0;
        end else if (rcnt == ((state == RS_DELAY) ? DLY_LAST : RATE_LAST)) begin
          pulse     = key ? CTL_RIGHT : CTL_LEFT;
          rcnt_nxt  = '0;
          state_nxt = RS_RPT;
        end else begin
          rcnt_nxt = rcnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RS_IDLE;
      rcnt  <= '0;
      key   <= 1'b0;
      ctl   <= CTL_NONE;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
      key   <= key_nxt;
      ctl   <= pulse;
    end
  end

  a_ctl_legal: assert property (@(posedge clk) disable iff (!rst) ctl != (CTL_LEFT | CTL_RIGHT));
endmodule

// File: tb/tb_lane_key_input.sv
// Bench for lane_key_input: directed segment table, edge-exact sequences, randomized run vs. a schedule model.
module tb_lane_key_input;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;
  localparam int CW = 8;

  logic       clk = 1'b0, rst = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic [1:0] ctl, key_lvl;

  lane_key_input #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .btn_l(btn_l), .btn_r(btn_r), .ctl(ctl), .key_lvl(key_lvl)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int         p_cyc[$];
  logic [1:0] p_val[$];

  // reference model: raw sample history per key, stable levels, repeat schedule
  logic [1:0][D+1:0] hist;
  logic [1:0]        m_stab, m_prev, exp_ctl;
  bit                act;
  int                act_key, due;

  typedef struct {
    logic [1:0] btn;
    int         len;
    int         n_l;
    int         n_r;
    logic [1:0] lvl;
  } seg_t;
  seg_t tbl[12];

  task automatic check2(input string name, input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      if (errors <= 40) $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, got, want);
    end
  endtask

  task automatic check_i(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      if (errors <= 40) $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    hist = '0; m_stab = '0; m_prev = '0; exp_ctl = '0; act = 0; act_key = 0; due = 0;
  endtask

  // stable flips once the D synchronised samples before this edge all disagree with it;
  // ctl is the press edge of the level one cycle old, or a scheduled repeat
  task automatic model_edge(input logic [1:0] raw);
    logic [1:0] pl, ns;
    bit was, flip;
    pl  = '0;
    was = act;
    if (act && (!m_stab[act_key] || m_stab[1-act_key])) act = 0;
    if (act && cyc == due) begin pl[act_key] = 1'b1; due = due + RR; end
    for (int i = 0; i < 2; i++)
      if (m_stab[i] && !m_prev[i] && !m_stab[1-i]) begin
        pl[i] = 1'b1;
        if (!was) begin act = 1; act_key = i; due = cyc + RD; end
      end
    for (int i = 0; i < 2; i++) begin
      hist[i] = {hist[i][D:0], raw[i]};
      flip = 1;
      for (int k = 2; k <= D + 1; k++) if (hist[i][k] == m_stab[i]) flip = 0;
      ns[i] = flip ? ~m_stab[i] : m_stab[i];
    end
    m_prev  = m_stab;
    m_stab  = ns;
    exp_ctl = pl;
  endtask

  task automatic tick(input logic [1:0] b);
    btn_l = b[0]; btn_r = b[1];
    @(posedge clk);
    cyc++;
    model_edge(b);
    #1;
    check2("ctl", ctl, exp_ctl);
    check2("key_lvl", key_lvl, m_stab);
    if (ctl != 2'b00) begin p_cyc.push_back(cyc); p_val.push_back(ctl); end
  endtask

  task automatic hold(input logic [1:0] b, input int n);
    repeat (n) tick(b);
  endtask

  task automatic do_reset(input int n, input logic [1:0] b);
    rst = 1'b0; btn_l = b[0]; btn_r = b[1];
    model_reset();
    repeat (n) begin
      @(posedge clk); #1;
      check2("rst_ctl", ctl, 2'b00);
      check2("rst_key_lvl", key_lvl, 2'b00);
    end
    rst = 1'b1;
  endtask

  function automatic int npulse(input int from, input int to, input logic [1:0] v);
    int n = 0;
    foreach (p_cyc[i]) if (p_cyc[i] > from && p_cyc[i] <= to && p_val[i] == v) n++;
    return n;
  endfunction

  function automatic int first_pulse(input int from, input logic [1:0] v);
    foreach (p_cyc[i]) if (p_cyc[i] > from && p_val[i] == v) return p_cyc[i] - from;
    return -1;
  endfunction

  initial begin
    int t, t2;
    int offs[6];
    logic [1:0] b;

    tbl[0]  = '{2'b00,  6, 0, 0, 2'b00};
    tbl[1]  = '{2'b01,  3, 0, 0, 2'b00};  // one sample short of debounce
    tbl[2]  = '{2'b00, 10, 0, 0, 2'b00};
    tbl[3]  = '{2'b01,  4, 0, 0, 2'b00};  // exactly long enough; pulse lands in next segment
    tbl[4]  = '{2'b00, 12, 1, 0, 2'b00};
    tbl[5]  = '{2'b11, 15, 0, 0, 2'b11};
    tbl[6]  = '{2'b00, 10, 0, 0, 2'b00};
    tbl[7]  = '{2'b10, 12, 0, 1, 2'b10};
    tbl[8]  = '{2'b00, 10, 0, 0, 2'b00};
    tbl[9]  = '{2'b01,  8, 1, 0, 2'b01};
    tbl[10] = '{2'b11, 10, 0, 0, 2'b11};
    tbl[11] = '{2'b00, 12, 0, 0, 2'b00};
    offs = '{7, 27, 35, 43, 51, 59};

    // held key through reset must still be debounced in full afterwards
    do_reset(3, 2'b01);
    t = cyc;
    hold(2'b01, 10);
    check_i("t1_latency", first_pulse(t, 2'b01), 7);
    check_i("t1_count", npulse(t, cyc, 2'b01), 1);
    hold(2'b00, 12);

    t = cyc;
    hold(2'b01, 10);
    hold(2'b00, 12);
    check_i("t2_latency", first_pulse(t, 2'b01), 7);
    check_i("t2_left_count", npulse(t, cyc, 2'b01), 1);
    check_i("t2_right_count", npulse(t, cyc, 2'b10), 0);

    tick(2'b10); tick(2'b00); tick(2'b10); tick(2'b10); tick(2'b00);
    t = cyc;
    hold(2'b10, 12);
    check_i("t3_no_early", npulse(t - 5, t + 6, 2'b10), 0);
    check_i("t3_latency", first_pulse(t, 2'b10), 7);
    hold(2'b00, 12);

    foreach (tbl[i]) begin
      t = cyc;
      hold(tbl[i].btn, tbl[i].len);
      check_i($sformatf("seg%0d_left", i), npulse(t, cyc, 2'b01), tbl[i].n_l);
      check_i($sformatf("seg%0d_right", i), npulse(t, cyc, 2'b10), tbl[i].n_r);
      check2($sformatf("seg%0d_lvl", i), key_lvl, tbl[i].lvl);
    end

    t = cyc;
    hold(2'b10, 60);
    hold(2'b00, 30);
    check_i("t5_total", npulse(t, cyc, 2'b10), 6);
    foreach (offs[i]) check_i($sformatf("t5_pulse_at_%0d", offs[i]), npulse(t + offs[i] - 1, t + offs[i], 2'b10), 1);

    // other key becomes stable exactly in the cycle a repeat is due
    t = cyc;
    hold(2'b01, 28);
    t2 = cyc;
    hold(2'b11, 20);
    hold(2'b00, 15);
    check_i("t6_left_before", npulse(t, t2, 2'b01), 2);
    check_i("t6_left_after", npulse(t2, cyc, 2'b01), 0);
    check_i("t6_right", npulse(t2, cyc, 2'b10), 0);

    for (int s = 0; s < 90; s++) begin
      b = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 3), b);
      hold(b, $urandom_range(1, 40));
    end
    hold(2'b00, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
